// File: rtl/fifo_sm_pkg.sv
// Shared constants and helpers for the ECC FIFO safety monitor.
package fifo_sm_pkg;

   // One SEC-DED lane: 12 Hamming positions plus an overall parity bit
   localparam int unsigned ECC_LANE_W = 13;
   localparam int unsigned HAM_W      = 12;

   // Hamming position (1-based) of data bit Di; entry [0] is D0
   localparam logic [7:0][3:0] HAM_DATA_POS = {4'd12, 4'd11, 4'd10, 4'd9,
                                                4'd7,  4'd6,  4'd5,  4'd3};

   // Sticky status bit indices
   localparam int unsigned ERR_W    = 5;
   localparam int unsigned ERR_WPTR = 0;
   localparam int unsigned ERR_RPTR = 1;
   localparam int unsigned ERR_FLAG = 2;
   localparam int unsigned ERR_SEC  = 3;
   localparam int unsigned ERR_DED  = 4;

   // XOR of the 1-based positions of all set bits in a 12-bit Hamming word
   function automatic logic [3:0] ham_syndrome(input logic [HAM_W-1:0] w);
      logic [3:0] s;
      s = '0;
      for (int i = 0; i < int'(HAM_W); i++) begin
         if (w[i]) s = s ^ 4'(i + 1);
      end
      return s;
   endfunction

endpackage

// File: rtl/ecc_secded8_lane.sv
// Combinational SEC-DED encode and decode for one 8-bit lane.
module ecc_secded8_lane
   import fifo_sm_pkg::*;
(
   input  logic [7:0]            data_i,
   output logic [ECC_LANE_W-1:0] enc_o,
   input  logic [ECC_LANE_W-1:0] code_i,
   output logic [7:0]            data_o,
   output logic                  sec_o,
   output logic                  ded_o
);

   logic [HAM_W-1:0] enc_word;
   logic [3:0]       enc_syn;
   logic [HAM_W-1:0] fixed;
   logic [3:0]       dec_syn;
   logic             dec_par;

   // Encode: place data bits, then set check bits so the syndrome becomes zero
   always_comb begin
      enc_word = '0;
      for (int i = 0; i < 8; i++) begin
         enc_word[int'(HAM_DATA_POS[i]) - 1] = data_i[i];
      end
      enc_syn     = ham_syndrome(enc_word);
      enc_word[0] = enc_syn[0];
      enc_word[1] = enc_syn[1];
      enc_word[3] = enc_syn[2];
      enc_word[7] = enc_syn[3];
      enc_o       = {^enc_word, enc_word};
   end

   // Decode: classify by syndrome and overall parity; DED leaves bits raw
   always_comb begin
      dec_syn = ham_syndrome(code_i[HAM_W-1:0]);
      dec_par = ^code_i;
      fixed   = code_i[HAM_W-1:0];
      sec_o   = 1'b0;
      ded_o   = 1'b0;
      if (dec_par) begin
         if (dec_syn == 4'd0) begin
            sec_o = 1'b1;
         end else if (dec_syn <= 4'd12) begin
            fixed[dec_syn - 4'd1] = ~fixed[dec_syn - 4'd1];
            sec_o = 1'b1;
         end else begin
            ded_o = 1'b1;
         end
      end else if (dec_syn != 4'd0) begin
         ded_o = 1'b1;
      end
      data_o = '0;
      for (int i = 0; i < 8; i++) begin
         data_o[i] = fixed[int'(HAM_DATA_POS[i]) - 1];
      end
   end

endmodule

// File: rtl/fifo_ecc_sm.sv
// Safety monitor for the ECC FIFO: encodes writes, corrects reads, shadows
// the DUT pointers/flags and records mismatches and ECC events.
module fifo_ecc_sm
   import fifo_sm_pkg::*;
#(
   parameter  int unsigned DATA_WIDTH = 32,
   parameter  int unsigned ADDR_WIDTH = 8,
   parameter  int unsigned CNT_WIDTH  = 16,
   localparam int unsigned LANES      = DATA_WIDTH / 8,
   localparam int unsigned ENC_WIDTH  = LANES * ECC_LANE_W
)(
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  WriteEn,
   input  logic                  ReadEn,
   input  logic                  Empty_,
   input  logic                  HalfFull_,
   input  logic                  Full_,
   input  logic [ADDR_WIDTH-1:0] DutWritePtr,
   input  logic [ADDR_WIDTH-1:0] DutReadPtr,
   input  logic [DATA_WIDTH-1:0] DataIn,
   output logic [ENC_WIDTH-1:0]  DataInEnc,
   input  logic [ENC_WIDTH-1:0]  DataOutEnc,
   input  logic                  RdValid,
   output logic [DATA_WIDTH-1:0] DataOut,
   output logic                  DataOutValid,
   input  logic                  ErrClear,
   output logic [ERR_W-1:0]      ErrStatus,
   output logic [CNT_WIDTH-1:0]  SecCount,
   output logic [CNT_WIDTH-1:0]  DedCount,
   output logic                  detected_error
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
   localparam int unsigned CW    = ADDR_WIDTH + 1;

   logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [ENC_WIDTH-1:0]  enc_q;
   logic                  rdv_q;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  dval_q;
   logic [ERR_W-1:0]      err_q, err_d, ev;
   logic [CNT_WIDTH-1:0]  sec_q, sec_d, ded_q, ded_d, sec_base, ded_base;
   logic                  det_q;

   logic                  do_write, do_read;
   logic                  sm_empty_n, sm_half_n, sm_full_n;
   logic [DATA_WIDTH-1:0] dec_data;
   logic [LANES-1:0]      lane_sec, lane_ded;

   // One encoder/decoder per data byte; decode works on the registered word
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      ecc_secded8_lane u_lane (
         .data_i (DataIn[8*k +: 8]),
         .enc_o  (DataInEnc[ECC_LANE_W*k +: ECC_LANE_W]),
         .code_i (enc_q[ECC_LANE_W*k +: ECC_LANE_W]),
         .data_o (dec_data[8*k +: 8]),
         .sec_o  (lane_sec[k]),
         .ded_o  (lane_ded[k])
      );
   end

   // Shadow pointer/count next state, using the DUT's own flags to qualify
   always_comb begin
      do_write = WriteEn & Full_;
      do_read  = ReadEn & Empty_;
      wptr_d   = do_write ? wptr_q + ADDR_WIDTH'(1) : wptr_q;
      rptr_d   = do_read  ? rptr_q + ADDR_WIDTH'(1) : rptr_q;
      cnt_d    = cnt_q;
      if (do_write && !do_read && cnt_q != CW'(DEPTH)) begin
         cnt_d = cnt_q + CW'(1);
      end else if (do_read && !do_write && cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end
      sm_empty_n = (cnt_q != '0);
      sm_full_n  = (cnt_q != CW'(DEPTH));
      sm_half_n  = (cnt_q < CW'(DEPTH / 2));
   end

   // Event detection and sticky status/counter update; events beat ErrClear
   always_comb begin
      ev           = '0;
      ev[ERR_WPTR] = (DutWritePtr != wptr_q);
      ev[ERR_RPTR] = (DutReadPtr != rptr_q);
      ev[ERR_FLAG] = (Empty_ != sm_empty_n) | (HalfFull_ != sm_half_n) |
                     (Full_ != sm_full_n);
      ev[ERR_DED]  = rdv_q & (|lane_ded);
      ev[ERR_SEC]  = rdv_q & (|lane_sec) & ~(|lane_ded);
      err_d        = (ErrClear ? '0 : err_q) | ev;
      sec_base     = ErrClear ? '0 : sec_q;
      ded_base     = ErrClear ? '0 : ded_q;
      sec_d        = (ev[ERR_SEC] && sec_base != '1) ? sec_base + CNT_WIDTH'(1) : sec_base;
      ded_d        = (ev[ERR_DED] && ded_base != '1) ? ded_base + CNT_WIDTH'(1) : ded_base;
      dout_d       = rdv_q ? dec_data : dout_q;
   end

   // All monitor state
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         enc_q  <= '0;
         rdv_q  <= 1'b0;
         dout_q <= '0;
         dval_q <= 1'b0;
         err_q  <= '0;
         sec_q  <= '0;
         ded_q  <= '0;
         det_q  <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
         enc_q  <= DataOutEnc;
         rdv_q  <= RdValid;
         dout_q <= dout_d;
         dval_q <= rdv_q;
         err_q  <= err_d;
         sec_q  <= sec_d;
         ded_q  <= ded_d;
         det_q  <= |err_d;
      end
   end

   assign DataOut        = dout_q;
   assign DataOutValid   = dval_q;
   assign ErrStatus      = err_q;
   assign SecCount       = sec_q;
   assign DedCount       = ded_q;
   assign detected_error = det_q;

endmodule

// File: tb/tb_fifo_ecc_sm.sv
// Directed bench for fifo_ecc_sm: shadow tracking, ECC table, sticky status.
module tb_fifo_ecc_sm;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        WriteEn, ReadEn, Empty_, HalfFull_, Full_;
   logic [7:0]  DutWritePtr, DutReadPtr;
   logic [31:0] DataIn;
   logic [51:0] DataInEnc;
   logic [51:0] DataOutEnc;
   logic        RdValid;
   logic [31:0] DataOut;
   logic        DataOutValid;
   logic        ErrClear;
   logic [4:0]  ErrStatus;
   logic [15:0] SecCount, DedCount;
   logic        detected_error;

   int n_cmp = 0;
   int n_err = 0;

   // Bench-side shadow model and expected status
   logic [7:0]  m_wptr, m_rptr;
   int          m_cnt;
   logic [4:0]  e_st;
   int          e_sec, e_ded;

   typedef struct {
      logic [31:0] data;
      logic [51:0] flip;
      logic [31:0] exp_data;
      logic        exp_sec;
      logic        exp_ded;
   } ecc_vec_t;

   ecc_vec_t vecs[12];

   fifo_ecc_sm dut (
      .Clock          (Clock),
      .Reset          (Reset),
      .WriteEn        (WriteEn),
      .ReadEn         (ReadEn),
      .Empty_         (Empty_),
      .HalfFull_      (HalfFull_),
      .Full_          (Full_),
      .DutWritePtr    (DutWritePtr),
      .DutReadPtr     (DutReadPtr),
      .DataIn         (DataIn),
      .DataInEnc      (DataInEnc),
      .DataOutEnc     (DataOutEnc),
      .RdValid        (RdValid),
      .DataOut        (DataOut),
      .DataOutValid   (DataOutValid),
      .ErrClear       (ErrClear),
      .ErrStatus      (ErrStatus),
      .SecCount       (SecCount),
      .DedCount       (DedCount),
      .detected_error (detected_error)
   );

   always #5 Clock = ~Clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference lane encoder written from explicit check-bit equations
   function automatic logic [12:0] ref_lane(input logic [7:0] d);
      logic [12:0] c;
      c = '0;
      c[2]  = d[0]; c[4]  = d[1]; c[5]  = d[2]; c[6]  = d[3];
      c[8]  = d[4]; c[9]  = d[5]; c[10] = d[6]; c[11] = d[7];
      c[0]  = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
      c[1]  = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
      c[3]  = d[1] ^ d[2] ^ d[3] ^ d[7];
      c[7]  = d[4] ^ d[5] ^ d[6] ^ d[7];
      c[12] = ^c[11:0];
      return c;
   endfunction

   function automatic logic [51:0] ref_enc(input logic [31:0] d);
      logic [51:0] e;
      for (int k = 0; k < 4; k++) e[13*k +: 13] = ref_lane(d[8*k +: 8]);
      return e;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      @(negedge Clock);
   endtask

   // Drive DUT pointers/flags consistent with the bench model
   task automatic drive_shadow();
      DutWritePtr = m_wptr;
      DutReadPtr  = m_rptr;
      Empty_      = (m_cnt != 0);
      HalfFull_   = (m_cnt < 128);
      Full_       = (m_cnt != 256);
   endtask

   task automatic check_status(input string tag);
      check({tag, " ErrStatus"}, 64'(ErrStatus), 64'(e_st));
      check({tag, " SecCount"}, 64'(SecCount), 64'(e_sec));
      check({tag, " DedCount"}, 64'(DedCount), 64'(e_ded));
      check({tag, " detected_error"}, 64'(detected_error), 64'(|e_st));
   endtask

   task automatic pulse_clear();
      ErrClear = 1'b1;
      tick();
      ErrClear = 1'b0;
      e_st = '0; e_sec = 0; e_ded = 0;
   endtask

   initial begin
      vecs[0]  = '{32'hDEADBEEF, 52'h0,             32'hDEADBEEF, 1'b0, 1'b0};
      vecs[1]  = '{32'hDEADBEEF, 52'h0000040000000, 32'hDEADBEEF, 1'b1, 1'b0};
      vecs[2]  = '{32'hDEADBEEF, 52'h0000000000021, 32'hDEADBEEB, 1'b0, 1'b1};
      vecs[3]  = '{32'hDEADBEEF, 52'h8000000000000, 32'hDEADBEEF, 1'b1, 1'b0};
      vecs[4]  = '{32'hDEADBEEF, 52'h0000001000000, 32'hDEADBEEF, 1'b1, 1'b0};
      vecs[5]  = '{32'hDEADBEEF, 52'h1800000008000, 32'hEEADBEEF, 1'b0, 1'b1};
      vecs[6]  = '{32'hDEADBEEF, 52'h0000000000803, 32'hDEADBE6F, 1'b0, 1'b1};
      vecs[7]  = '{32'h12345678, 52'h0,             32'h12345678, 1'b0, 1'b0};
      vecs[8]  = '{32'h00000000, 52'h0000000000004, 32'h00000000, 1'b1, 1'b0};
      vecs[9]  = '{32'hA5A5A5A5, 52'h0000004000040, 32'hA5A5A5A5, 1'b1, 1'b0};
      vecs[10] = '{32'hCAFEF00D, 52'h0400000000000, 32'hCAFEF00D, 1'b1, 1'b0};
      vecs[11] = '{32'h00000000, 52'h0004010000000, 32'h00010000, 1'b0, 1'b1};

      m_wptr = '0; m_rptr = '0; m_cnt = 0;
      e_st = '0; e_sec = 0; e_ded = 0;
      Reset = 1'b1;
      WriteEn = 1'b0; ReadEn = 1'b0; RdValid = 1'b0; ErrClear = 1'b0;
      DataIn = '0; DataOutEnc = '0;
      drive_shadow();

      // Reset values
      tick();
      check("rst DataOut", 64'(DataOut), 64'h0);
      check("rst DataOutValid", 64'(DataOutValid), 64'h0);
      check_status("rst");
      Reset = 1'b0;
      tick();

      // Fill 256 words with matching DUT pointers/flags
      WriteEn = 1'b1;
      for (int k = 0; k < 256; k++) begin
         drive_shadow();
         tick();
         m_wptr = m_wptr + 8'd1;
         m_cnt++;
      end
      WriteEn = 1'b0;
      drive_shadow();
      tick();
      tick();
      check("fill wptr wrapped", 64'(DutWritePtr), 64'h0);
      check("fill full flag", 64'(Full_), 64'h0);
      check_status("fill");

      // Single-cycle flag and pointer disagreements
      Full_ = 1'b1;
      tick();
      drive_shadow();
      e_st = 5'b00100;
      check_status("flag err");
      DutWritePtr = 8'hFF;
      tick();
      drive_shadow();
      e_st = 5'b00101;
      check_status("wptr err");
      pulse_clear();
      check_status("clear1");

      // Encoder constant anchor
      DataIn = 32'h000000FF;
      #1;
      check("enc 0xFF", 64'(DataInEnc), 64'h0000000000F77);

      // ECC vector table through the loopback read path
      for (int i = 0; i < 12; i++) begin
         DataIn     = vecs[i].data;
         DataOutEnc = ref_enc(vecs[i].data) ^ vecs[i].flip;
         RdValid    = 1'b1;
         #1;
         check($sformatf("vec%0d DataInEnc", i), 64'(DataInEnc), 64'(ref_enc(vecs[i].data)));
         tick();
         RdValid = 1'b0;
         check($sformatf("vec%0d valid low", i), 64'(DataOutValid), 64'h0);
         tick();
         if (vecs[i].exp_ded) begin
            e_ded++; e_st[4] = 1'b1;
         end else if (vecs[i].exp_sec) begin
            e_sec++; e_st[3] = 1'b1;
         end
         check($sformatf("vec%0d DataOut", i), 64'(DataOut), 64'(vecs[i].exp_data));
         check($sformatf("vec%0d valid", i), 64'(DataOutValid), 64'h1);
         check_status($sformatf("vec%0d", i));
      end

      // Two reads move the shadow read pointer to 2
      pulse_clear();
      ReadEn = 1'b1;
      for (int k = 0; k < 2; k++) begin
         drive_shadow();
         tick();
         m_rptr = m_rptr + 8'd1;
         m_cnt--;
      end
      ReadEn = 1'b0;
      drive_shadow();
      tick();
      check_status("after reads");

      // DUT read pointer ahead of shadow
      DutReadPtr = 8'h03;
      tick();
      drive_shadow();
      e_st = 5'b00010;
      check_status("rptr err");
      pulse_clear();
      check_status("clear2");

      // Held DED injection across an ErrClear pulse
      DataIn     = 32'hDEADBEEF;
      DataOutEnc = ref_enc(32'hDEADBEEF) ^ 52'h21;
      RdValid    = 1'b1;
      tick(); tick(); tick();
      e_ded = 2; e_st = 5'b10000;
      check_status("ded hold");
      pulse_clear();
      e_ded = 1; e_st = 5'b10000;
      check_status("ded vs clear");
      check("ded hold DataOut", 64'(DataOut), 64'hDEADBEEB);
      check("pre-reset valid", 64'(DataOutValid), 64'h1);

      // Asynchronous reset during an active read
      Reset = 1'b1;
      #1;
      e_st = '0; e_sec = 0; e_ded = 0;
      check("async rst valid", 64'(DataOutValid), 64'h0);
      check("async rst DataOut", 64'(DataOut), 64'h0);
      check_status("async rst");
      tick();
      RdValid = 1'b0;
      Reset = 1'b0;
      tick();
      check("post-rst valid", 64'(DataOutValid), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
